lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
Parametrised load/store unit that sits between the core datapath and the data-memory and memory-mapped IO buses. It replaces the fixed one-cycle data access and single IO strobe with three additions:
- byte/half/word accesses with sign/zero extension;
- a request/acknowledge memory handshake with a timeout;
- NUM_IO decoded IO channels.

The core stalls on core_stall until the access completes.

Parameters:
NUM_IO, 4, number of IO channels (1..64); each channel is one 32-bit word.
IO_BASE, 32'hFFFF_FF00, base of the IO region; only bits [31:8] are compared.
TIMEOUT, 15, maximum cycles to wait for mem_ack before flagging an error (1..255).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
core_req  in  1  access request; core holds all core_* inputs stable while core_stall=1
core_we  in  1  1=store, 0=load
core_funct3  in  3  RISC-V funct3: [1:0] 00 byte, 01 half, 10 word; [2]=1 zero-extend load
core_addr  in  32  byte address
core_wdata  in  32  store data, LSB-aligned
core_rdata  out  32  extended load data, valid when state=DONE
core_stall  out  1  hold PC/writeback
core_err  out  1  timeout/misalign flag, valid when state=DONE
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_be  out  4  byte enables
mem_addr  out  32  word address ({core_addr[31:2],2'b00})
mem_wdata  out  32  replicated store data
mem_rdata  in  32  memory read word
mem_ack  in  1  memory completion, one-cycle pulse
io_sel  out  NUM_IO  one-hot channel strobe, one cycle
io_we  out  1  IO write
io_wdata  out  32  replicated store data
io_rdata  in  NUM_IO*32  channel k read word on bits [32k+31:32k]

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset is asynchronous and aborts any access mid-operation; mem_req drops immediately.
- States: IDLE, MEM, DONE.
- core_stall = core_req & (state!=DONE). It is combinational, so a new request stalls in its first cycle.
- Decode, in IDLE with core_req=1:
  - is_io = (core_addr[31:8]==IO_BASE[31:8]).
  - IO channel index ch = core_addr[7:2].
- IO access:
  - IDLE -> DONE.
  - io_sel[ch] pulses in the IDLE cycle only if ch<NUM_IO; io_we=core_we.
  - io_rdata word for ch is registered.
  - If ch>=NUM_IO: read word = 0, store dropped, core_err=0.
  - Total stall: 1 cycle.
- Memory access:
  - IDLE -> MEM. mem_req=1 with mem_we, mem_be, mem_addr, mem_wdata registered on entry.
  - On mem_ack: register mem_rdata, MEM -> DONE, mem_req=0.
  - Counter increments each MEM cycle. At counter==TIMEOUT without ack: DONE with core_err=1, read word 0, mem_req dropped.
  - mem_ack in the same cycle as the timeout: ack wins, core_err=0.
  - Minimum stall: 2 cycles (ack in first MEM cycle).
- DONE:
  - core_rdata and core_err valid for exactly one cycle; core_stall=0.
  - Returns to IDLE next cycle; core_err is cleared there.
  - A back-to-back request re-enters decode from IDLE.
- Byte enables:
  - byte: 4'b0001<<a[1:0].
  - half: 4'b0011<<{a[1],1'b0}.
  - word: 4'b1111.
  - funct3[1:0]=11 is treated as word.
- Store data:
  - byte replicated x4; half replicated x2; word as-is.
  - IO stores always write the full replicated word.
- Load extraction: word >> (8*a[1:0]), or >> (16*a[1]) for halves, then sign-extend unless funct3[2]=1.
- core_req deasserted mid-MEM: the transaction still completes or times out; the DONE result is discarded.
- mem_ack in IDLE or DONE is ignored.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: a half access with a[0]=1, or a word access with a[1:0]!=0, issues no bus or IO access. IDLE -> DONE with core_err=1, core_rdata=0.
- Undefined: the low offending address bits are ignored, i.e. the access is forced aligned. core_err is only ever set by timeout.

Test Plan:
- lw 0x100, mem_ack 3rd MEM cycle with rdata 0xDEADBEEF -> mem_be=1111; stall 4 cycles; DONE core_rdata=0xDEADBEEF, core_err=0.
- lb 0x103 then lbu 0x103, rdata 0x80FF_0000 -> mem_be=1000; core_rdata 0xFFFFFF80 then 0x00000080.
- sh 0x202 wdata 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
- sw 0xFFFFFF08 wdata 5 with NUM_IO=4 -> io_sel=0100 one cycle, io_we=1, 1 stall cycle; lw 0xFFFFFF40 -> io_sel=0, core_rdata=0, no error.
- lw with no mem_ack, TIMEOUT=15 -> mem_req high for 15 cycles, then DONE core_err=1, rdata 0. Repeat with ack on cycle 15 -> core_err=0.
- lw 0x102 -> with MISALIGN_TRAP_EN: no mem_req, core_err=1. Without: mem_addr 0x100, mem_be 1111. Also reset asserted mid-MEM -> mem_req and core_stall 0 immediately.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: byte/half/word accesses to data memory (req/ack with timeout) and NUM_IO decoded IO words.
// Latency: IO access stalls 1 cycle; memory access stalls 1 + MEM cycles (min 2); result valid for one DONE cycle.
// Backpressure: core_stall holds the core until DONE; mem_req is held until mem_ack or timeout. Option: MISALIGN_TRAP_EN.
module lsu_bus_ctrl #(
  parameter int          NUM_IO  = 4,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00,
  parameter int          TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [31:0]           core_addr,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_stall,
  output logic                  core_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [NUM_IO-1:0]     io_sel,
  output logic                  io_we,
  output logic [31:0]           io_wdata,
  input  logic [NUM_IO*32-1:0]  io_rdata
);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        is_io, ch_ok, misalign, start, io_go, timeout;
  logic [5:0]  ch;
  logic [3:0]  be;
  logic [31:0] wdata_rep, io_word;

  // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] s;
    logic [31:0] r;
    s = w;
    r = w;
    case (f3[1:0])
      2'b00: begin
        s = w >> {off, 3'b000};
        r = f3[2] ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      end
      2'b01: begin
        s = w >> {off[1], 4'b0000};
        r = f3[2] ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      end
      default: r = w;
    endcase
    return r;
  endfunction

  assign is_io   = (core_addr[31:8] == IO_BASE[31:8]);
  assign ch      = core_addr[7:2];
  assign ch_ok   = (int'(ch) < NUM_IO);
  assign timeout = (cnt == 8'(TIMEOUT - 1));

`ifdef MISALIGN_TRAP_EN
  // Misaligned half/word accesses are trapped before any bus or IO activity.
  assign misalign = ((core_funct3[1:0] == 2'b01) && core_addr[0]) ||
                    (core_funct3[1] && (core_addr[1:0] != 2'b00));
`else
  // Offending low address bits are simply ignored, which forces alignment.
  assign misalign = 1'b0;
`endif

  assign start = reset_n && core_req && (state == IDLE);
  assign io_go = start && is_io && !misalign && ch_ok;

  // Byte enables and replicated store data from access size and offset; 2'b11 acts as word.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = core_wdata;
    case (core_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << core_addr[1:0];
        wdata_rep = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {core_addr[1], 1'b0};
        wdata_rep = {2{core_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // IO read mux and one-hot channel strobe; out-of-range channels read 0 and strobe nothing.
  always_comb begin
    io_word = 32'd0;
    io_sel  = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (ch == 6'(k)) io_word = io_rdata[32*k +: 32];
      io_sel[k] = io_go && (ch == 6'(k));
    end
  end

  // State register; asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus combinational core/IO outputs, all gated by reset so they drop immediately.
  always_comb begin
    state_nxt  = state;
    core_stall = reset_n && core_req && (state != DONE);
    core_rdata = (state == DONE) ? rdata_q : 32'd0;
    core_err   = (state == DONE) && err_q;
    io_we      = io_go && core_we;
    io_wdata   = io_go ? wdata_rep : 32'd0;
    case (state)
      IDLE:    if (core_req) state_nxt = (is_io || misalign) ? DONE : MEM;
      MEM:     if (mem_ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request registers, timeout counter and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 8'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= 8'd0;
          err_q <= 1'b0;
          if (core_req) begin
            f3_q  <= core_funct3;
            off_q <= core_addr[1:0];
            if (misalign) begin
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else if (is_io) begin
              rdata_q <= ch_ok ? extract(io_word, core_funct3, core_addr[1:0]) : 32'd0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= core_we;
              mem_be    <= be;
              mem_addr  <= {core_addr[31:2], 2'b00};
              mem_wdata <= wdata_rep;
            end
          end
        end
        MEM: begin
          cnt <= cnt + 8'd1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdata_q <= extract(mem_rdata, f3_q, off_q);
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed testbench for lsu_bus_ctrl with default parameters (NUM_IO=4, TIMEOUT=15).
// Inputs change just after the falling edge; outputs are sampled one time unit later.
// Each scenario task performs its own comparisons against hand-computed values.
module tb_lsu_bus_ctrl;
  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               core_req = 1'b0;
  logic               core_we = 1'b0;
  logic [2:0]         core_funct3 = 3'd0;
  logic [31:0]        core_addr = 32'd0;
  logic [31:0]        core_wdata = 32'd0;
  logic [31:0]        core_rdata;
  logic               core_stall, core_err;
  logic               mem_req, mem_we;
  logic [3:0]         mem_be;
  logic [31:0]        mem_addr, mem_wdata;
  logic [31:0]        mem_rdata = 32'd0;
  logic               mem_ack = 1'b0;
  logic [3:0]         io_sel;
  logic               io_we;
  logic [31:0]        io_wdata;
  logic [127:0]       io_rdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_1234, 32'h0A0B_0C0D};

  int errors = 0;
  int checks = 0;

  int          stalls, req_cycles;
  logic [31:0] got_rdata, seen_addr, seen_wdata;
  logic        got_err, seen_we;
  logic [3:0]  seen_be;

  lsu_bus_ctrl #(.NUM_IO(4), .IO_BASE(32'hFFFF_FF00), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_err(core_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_sel(io_sel), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wd;
    #1;
  endtask

  // Steps the access to DONE, pulsing mem_ack in MEM cycle ack_cycle (0 = never).
  task automatic run_mem(input int ack_cycle, input logic [31:0] rd);
    int n;
    n = 0;
    req_cycles = 0; seen_be = 4'd0; seen_addr = 32'd0; seen_wdata = 32'd0; seen_we = 1'b0;
    mem_rdata = rd;
    while (core_stall && n < 200) begin
      n++;
      if (mem_req) begin
        req_cycles++;
        seen_be = mem_be; seen_addr = mem_addr; seen_wdata = mem_wdata; seen_we = mem_we;
      end
      mem_ack = (ack_cycle > 0) && (n - 1 == ack_cycle);
      @(posedge clk); #1; mem_ack = 1'b0;
      @(negedge clk); #1;
    end
    stalls = n; got_rdata = core_rdata; got_err = core_err;
    checks++;
    if (core_stall !== 1'b0) begin errors++; $display("FAIL done_bound: stall still %b after %0d cycles, required 0", core_stall, n); end
  endtask

  task automatic release_req();
    core_req = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({core_stall, core_err, mem_req, mem_we, io_we, io_sel, mem_be} !== 11'd0) begin errors++;
      $display("FAIL reset_ctrl: got %b required 0", {core_stall, core_err, mem_req, mem_we, io_we, io_sel, mem_be}); end
    checks++;
    if ({core_rdata, mem_addr, mem_wdata, io_wdata} !== 128'd0) begin errors++;
      $display("FAIL reset_data: got %h required 0", {core_rdata, mem_addr, mem_wdata, io_wdata}); end
    reset_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_word_load();
    issue(1'b0, 3'b010, 32'h100, 32'd0);
    checks++;
    if (core_stall !== 1'b1) begin errors++; $display("FAIL lw_first_stall: got %b required 1", core_stall); end
    run_mem(3, 32'hDEAD_BEEF);
    checks++;
    if (stalls != 4) begin errors++; $display("FAIL lw_stalls: got %0d required 4", stalls); end
    checks++;
    if (req_cycles != 3) begin errors++; $display("FAIL lw_req_cycles: got %0d required 3", req_cycles); end
    checks++;
    if (seen_be !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b required 1111", seen_be); end
    checks++;
    if (got_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got %h required deadbeef", got_rdata); end
    checks++;
    if (got_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b required 0", got_err); end
    release_req();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 3'b000, 32'h103, 32'd0);
    run_mem(1, 32'h80FF_0000);
    checks++;
    if (seen_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b required 1000", seen_be); end
    checks++;
    if (got_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h required ffffff80", got_rdata); end
    core_funct3 = 3'b100;
    @(negedge clk); #1;
    checks++;
    if (core_stall !== 1'b1) begin errors++; $display("FAIL b2b_restall: got %b required 1", core_stall); end
    run_mem(1, 32'h80FF_0000);
    checks++;
    if (got_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata: got %h required 00000080", got_rdata); end
    checks++;
    if (stalls != 2) begin errors++; $display("FAIL lbu_stalls: got %0d required 2", stalls); end
    release_req();
  endtask

  task automatic test_store_half();
    issue(1'b1, 3'b001, 32'h202, 32'h1234_ABCD);
    run_mem(2, 32'd0);
    checks++;
    if (seen_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b required 1100", seen_be); end
    checks++;
    if (seen_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h required abcdabcd", seen_wdata); end
    checks++;
    if (seen_addr !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h required 00000200", seen_addr); end
    checks++;
    if (seen_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b required 1", seen_we); end
    release_req();
  endtask

  task automatic test_io();
    issue(1'b1, 3'b010, 32'hFFFF_FF08, 32'd5);
    checks++;
    if ({io_sel, io_we} !== 5'b0100_1) begin errors++; $display("FAIL sw_io_sel_we: got %b required 01001", {io_sel, io_we}); end
    checks++;
    if (io_wdata !== 32'd5) begin errors++; $display("FAIL sw_io_wdata: got %h required 00000005", io_wdata); end
    run_mem(0, 32'd0);
    checks++;
    if (stalls != 1 || req_cycles != 0) begin errors++; $display("FAIL sw_io_stalls: got %0d/%0d required 1/0", stalls, req_cycles); end
    checks++;
    if (io_sel !== 4'b0000) begin errors++; $display("FAIL sw_io_pulse: got %b required 0000", io_sel); end
    release_req();
    issue(1'b0, 3'b010, 32'hFFFF_FF40, 32'd0);
    checks++;
    if (io_sel !== 4'b0000) begin errors++; $display("FAIL io_oor_sel: got %b required 0000", io_sel); end
    run_mem(0, 32'd0);
    checks++;
    if ({got_rdata, got_err} !== 33'd0) begin errors++; $display("FAIL io_oor_read: got %h/%b required 0/0", got_rdata, got_err); end
    release_req();
    issue(1'b0, 3'b000, 32'hFFFF_FF05, 32'd0);
    checks++;
    if ({io_sel, io_we} !== 5'b0010_0) begin errors++; $display("FAIL lb_io_sel: got %b required 00100", {io_sel, io_we}); end
    run_mem(0, 32'd0);
    checks++;
    if (got_rdata !== 32'h0000_0012) begin errors++; $display("FAIL lb_io_rdata: got %h required 00000012", got_rdata); end
    release_req();
    issue(1'b1, 3'b000, 32'hFFFF_FF0C, 32'h0000_00A5);
    checks++;
    if ({io_sel, io_wdata} !== {4'b1000, 32'hA5A5_A5A5}) begin errors++;
      $display("FAIL sb_io: got %b/%h required 1000/a5a5a5a5", io_sel, io_wdata); end
    run_mem(0, 32'd0);
    release_req();
  endtask

  task automatic test_timeout();
    issue(1'b0, 3'b010, 32'h300, 32'd0);
    run_mem(0, 32'h5555_5555);
    checks++;
    if (req_cycles != 15 || stalls != 16) begin errors++; $display("FAIL to_cycles: got %0d/%0d required 15/16", req_cycles, stalls); end
    checks++;
    if ({got_err, got_rdata} !== {1'b1, 32'd0}) begin errors++; $display("FAIL to_result: got %b/%h required 1/0", got_err, got_rdata); end
    release_req();
    checks++;
    if (core_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b required 0", core_err); end
    issue(1'b0, 3'b010, 32'h300, 32'd0);
    run_mem(15, 32'h1357_9BDF);
    checks++;
    if ({got_err, got_rdata} !== {1'b0, 32'h1357_9BDF}) begin errors++; $display("FAIL to_ack_wins: got %b/%h required 0/13579bdf", got_err, got_rdata); end
    checks++;
    if (req_cycles != 15) begin errors++; $display("FAIL to_ack_cycles: got %0d required 15", req_cycles); end
    release_req();
  endtask

  task automatic test_misalign();
    issue(1'b0, 3'b010, 32'h102, 32'd0);
    run_mem(1, 32'h1122_3344);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (stalls != 1 || req_cycles != 0) begin errors++; $display("FAIL mis_trap_bus: got %0d/%0d required 1/0", stalls, req_cycles); end
    checks++;
    if ({got_err, got_rdata} !== {1'b1, 32'd0}) begin errors++; $display("FAIL mis_trap_result: got %b/%h required 1/0", got_err, got_rdata); end
`else
    checks++;
    if ({seen_addr, seen_be} !== {32'h100, 4'b1111}) begin errors++; $display("FAIL mis_align_bus: got %h/%b required 100/1111", seen_addr, seen_be); end
    checks++;
    if ({got_err, got_rdata} !== {1'b0, 32'h1122_3344}) begin errors++; $display("FAIL mis_align_result: got %b/%h required 0/11223344", got_err, got_rdata); end
`endif
    release_req();
  endtask

  task automatic test_req_drop();
    issue(1'b0, 3'b010, 32'h500, 32'd0);
    @(negedge clk); #1;
    core_req = 1'b0; #1;
    checks++;
    if ({core_stall, mem_req} !== 2'b01) begin errors++; $display("FAIL drop_mid_mem: got %b required 01", {core_stall, mem_req}); end
    mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL drop_req_low: got %b required 0", mem_req); end
    @(negedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({mem_req, core_stall} !== 2'b00) begin errors++; $display("FAIL idle_ack_ignored: got %b required 00", {mem_req, core_stall}); end
    issue(1'b0, 3'b001, 32'h106, 32'd0);
    run_mem(1, 32'h9ABC_0000);
    checks++;
    if (got_rdata !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_after_drop: got %h required ffff9abc", got_rdata); end
    release_req();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b010, 32'h600, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b required 1", mem_req); end
    reset_n = 1'b0; #1;
    checks++;
    if ({mem_req, core_stall} !== 2'b00) begin errors++; $display("FAIL rst_mid_mem: got %b required 00", {mem_req, core_stall}); end
    core_req = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_back_to_back();
    test_store_half();
    test_io();
    test_timeout();
    test_misalign();
    test_req_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
